// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-rate enable, syncs, active flag and 1-based coordinates.
// Optional frame counter port o_frame_cnt is built when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_NEG = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_pix_en,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_active,
   output logic [10:0] o_x,
   output logic [9:0]  o_y,
   output logic        o_frame_start
`ifdef VGA_FRAME_CNT_EN
  ,output logic [15:0] o_frame_cnt
`endif
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int DW       = $clog2(CLK_DIV);
   localparam int H_SYNC_S = H_ACTIVE + H_FP;
   localparam int V_SYNC_S = V_ACTIVE + V_FP;

   function automatic logic sync_level(input logic in_sync);
      return (SYNC_NEG != 0) ? ~in_sync : in_sync;
   endfunction

   function automatic logic h_in_sync(input logic [HW-1:0] h);
      return (int'(h) >= H_SYNC_S) && (int'(h) < H_SYNC_S + H_SYNC);
   endfunction

   function automatic logic v_in_sync(input logic [VW-1:0] v);
      return (int'(v) >= V_SYNC_S) && (int'(v) < V_SYNC_S + V_SYNC);
   endfunction

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          pix_en_q, pix_en_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          active_q, active_d;
   logic [10:0]   x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          frame_start_q, frame_start_d;
   logic          tick;
   logic          at_origin;
   logic          pix_active;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   logic          seen_first_q, seen_first_d;
`endif

   always_comb begin
      tick       = (div_cnt_q == DW'(CLK_DIV - 1));
      at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
      pix_active = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);

      div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);

      // Counters step the cycle after the pixel enable, well before the next decode at tick.
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (pix_en_q) begin
         if (h_cnt_q == HW'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
         end else begin
            h_cnt_d = h_cnt_q + HW'(1);
         end
      end

      pix_en_d      = tick;
      frame_start_d = tick && at_origin;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      active_d      = active_q;
      x_d           = x_q;
      y_d           = y_q;
      if (tick) begin
         hsync_d  = sync_level(h_in_sync(h_cnt_q));
         vsync_d  = sync_level(v_in_sync(v_cnt_q));
         active_d = pix_active;
         x_d      = pix_active ? 11'(int'(h_cnt_q) + 1) : '0;
         y_d      = pix_active ? 10'(int'(v_cnt_q) + 1) : '0;
      end

`ifdef VGA_FRAME_CNT_EN
      // The first frame start after reset opens frame 0; later ones close a frame.
      frame_cnt_d  = frame_cnt_q;
      seen_first_d = seen_first_q;
      if (tick && at_origin) begin
         seen_first_d = 1'b1;
         if (seen_first_q) frame_cnt_d = frame_cnt_q + 16'd1;
      end
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_cnt_q     <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         pix_en_q      <= 1'b0;
         hsync_q       <= sync_level(1'b0);
         vsync_q       <= sync_level(1'b0);
         active_q      <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pix_en_q      <= pix_en_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         active_q      <= active_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         frame_cnt_q  <= '0;
         seen_first_q <= 1'b0;
      end else begin
         frame_cnt_q  <= frame_cnt_d;
         seen_first_q <= seen_first_d;
      end
   end

   assign o_frame_cnt = frame_cnt_q;
`endif

   assign o_pix_en      = pix_en_q;
   assign o_hsync       = hsync_q;
   assign o_vsync       = vsync_q;
   assign o_active      = active_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster, checked every cycle against
// an arithmetic model that derives all outputs from the clock count since reset release.
module tb_vga_timing_gen;

   localparam int CD  = 3;
   localparam int HA  = 8;
   localparam int HFP = 2;
   localparam int HS  = 3;
   localparam int HBP = 2;
   localparam int VA  = 5;
   localparam int VFP = 1;
   localparam int VS  = 2;
   localparam int VBP = 1;
   localparam int HT  = HA + HFP + HS + HBP;
   localparam int VT  = VA + VFP + VS + VBP;
   localparam int FT  = HT * VT;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_en, hsync, vsync, active, frame_start;
   logic [10:0] x;
   logic [9:0]  y;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int k       = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_NEG(1)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .o_pix_en      (pix_en),
      .o_hsync       (hsync),
      .o_vsync       (vsync),
      .o_active      (active),
      .o_x           (x),
      .o_y           (y),
      .o_frame_start (frame_start)
`ifdef VGA_FRAME_CNT_EN
     ,.o_frame_cnt   (frame_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (k=%0d, t=%0t)", tag, got, exp, k, $time);
      end
   endtask

   // k = rising edges seen since reset release; pixel n is shown from edge (n+1)*CD onward.
   task automatic check_outputs();
      int   n, h, v;
      logic e_pe, e_hs, e_vs, e_act, e_fs;
      int   e_x, e_y, e_fc;
      e_pe = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_fs = 1'b0;
      e_x = 0; e_y = 0; e_fc = 0;
      if (rst_n && k >= CD) begin
         n     = k / CD - 1;
         h     = n % HT;
         v     = (n / HT) % VT;
         e_pe  = (k % CD == 0);
         e_act = (h < HA) && (v < VA);
         e_x   = e_act ? h + 1 : 0;
         e_y   = e_act ? v + 1 : 0;
         e_hs  = !((h >= HA + HFP) && (h < HA + HFP + HS));
         e_vs  = !((v >= VA + VFP) && (v < VA + VFP + VS));
         e_fs  = e_pe && (n % FT == 0);
         e_fc  = (n / FT) % 65536;
      end
      chk("pix_en",      32'(pix_en),      32'(e_pe));
      chk("hsync",       32'(hsync),       32'(e_hs));
      chk("vsync",       32'(vsync),       32'(e_vs));
      chk("active",      32'(active),      32'(e_act));
      chk("x",           32'(x),           32'(e_x));
      chk("y",           32'(y),           32'(e_y));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
`ifdef VGA_FRAME_CNT_EN
      chk("frame_cnt",   32'(frame_cnt),   32'(e_fc));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) k++;
      #2;
      check_outputs();
   endtask

   initial begin
      int run, hold;
      rst_n = 1'b0;
      k     = 0;
      repeat (10) step();
      rst_n = 1'b1;
      repeat (3 * FT * CD + 20) step();
      for (int it = 0; it < 8; it++) begin
         run = $urandom_range(1, 2 * FT * CD);
         repeat (run) step();
         #($urandom_range(1, 4));
         rst_n = 1'b0;
         k     = 0;
         #1;
         check_outputs();
         hold = $urandom_range(1, 4);
         repeat (hold) step();
         rst_n = 1'b1;
      end
      repeat (FT * CD + 4 * CD) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
